// File: rtl/duck_hunt_pkg.sv
// Shared screen geometry, palette and hunter FSM encoding for the duck-hunt game.
// Imported by the crosshair engine and its offset table.
package duck_hunt_pkg;

  localparam int SCREEN_W         = 160;
  localparam int SCREEN_H         = 120;
  localparam int CROSSHAIR_PIXELS = 9;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] RED   = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_UPDATE,
    ST_DRAW,
    ST_DONE
  } hunter_state_e;

endpackage

// File: rtl/crosshair_offset_lut.sv
// Combinational map from plus-shape pixel index to signed (dx, dy) offset.
// Indices beyond the shape return (0, 0).
module crosshair_offset_lut (
  input  logic        [3:0] idx,
  output logic signed [2:0] dx,
  output logic signed [2:0] dy
);

  always_comb begin
    dx = 3'sd0;
    dy = 3'sd0;
    case (idx)
      4'd1: dx = -3'sd1;
      4'd2: dx = -3'sd2;
      4'd3: dx =  3'sd1;
      4'd4: dx =  3'sd2;
      4'd5: dy = -3'sd1;
      4'd6: dy = -3'sd2;
      4'd7: dy =  3'sd1;
      4'd8: dy =  3'sd2;
      default: ;
    endcase
  end

endmodule

// File: rtl/hunter_crosshair.sv
// Crosshair sprite engine: per start pulse erases, moves and redraws a 9-pixel plus, one pixel per clock.
// Optional HUNTER_FIRE_FLASH_EN adds a fire input that flashes the redraw red and pulses shot with done.
module hunter_crosshair
  import duck_hunt_pkg::*;
#(
  parameter int         X_MAX       = SCREEN_W - 1,
  parameter int         Y_MAX       = SCREEN_H - 1,
  parameter int         X_INIT      = 80,
  parameter int         Y_INIT      = 60,
  parameter int         STEP        = 1,
  parameter logic [2:0] DRAW_COLOUR = BLUE
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       mv_left,
  input  logic       mv_right,
  input  logic       mv_up,
  input  logic       mv_down,
`ifdef HUNTER_FIRE_FLASH_EN
  input  logic       fire,
  output logic       shot,
`endif
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic [7:0] cur_x,
  output logic [6:0] cur_y
);

  localparam logic [3:0] LAST_IDX = 4'(CROSSHAIR_PIXELS - 1);

  hunter_state_e state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;

  logic signed [2:0] dx, dy;
  logic signed [8:0] px, py;
  logic              in_range;
  logic [2:0]        draw_col;

`ifdef HUNTER_FIRE_FLASH_EN
  logic fire_q, fire_d;
`endif

  crosshair_offset_lut u_lut (
    .idx (idx_q),
    .dx  (dx),
    .dy  (dy)
  );

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      x_q     <= 8'(X_INIT);
      y_q     <= 7'(Y_INIT);
`ifdef HUNTER_FIRE_FLASH_EN
      fire_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
`ifdef HUNTER_FIRE_FLASH_EN
      fire_q  <= fire_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
`ifdef HUNTER_FIRE_FLASH_EN
    fire_d  = fire_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ERASE;
          idx_d   = 4'd0;
`ifdef HUNTER_FIRE_FLASH_EN
          fire_d  = fire;
`endif
        end
      end
      ST_ERASE: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_UPDATE;
          idx_d   = 4'd0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      ST_UPDATE: begin
        // Opposing requests on one axis cancel; each axis saturates at the screen edge.
        if (mv_left && !mv_right)
          x_d = (int'(x_q) < STEP) ? 8'd0 : 8'(int'(x_q) - STEP);
        else if (mv_right && !mv_left)
          x_d = (int'(x_q) + STEP > X_MAX) ? 8'(X_MAX) : 8'(int'(x_q) + STEP);
        if (mv_up && !mv_down)
          y_d = (int'(y_q) < STEP) ? 7'd0 : 7'(int'(y_q) - STEP);
        else if (mv_down && !mv_up)
          y_d = (int'(y_q) + STEP > Y_MAX) ? 7'(Y_MAX) : 7'(int'(y_q) + STEP);
        state_d = ST_DRAW;
        idx_d   = 4'd0;
      end
      ST_DRAW: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          idx_d   = 4'd0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef HUNTER_FIRE_FLASH_EN
        fire_d  = 1'b0;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Signed centre+offset; anything off-screen is suppressed rather than wrapped.
  always_comb begin
    px       = $signed({1'b0, x_q}) + $signed({{6{dx[2]}}, dx});
    py       = $signed({2'b00, y_q}) + $signed({{6{dy[2]}}, dy});
    in_range = !px[8] && (px[7:0] <= 8'(X_MAX)) && !py[8] && (py[7:0] <= 8'(Y_MAX));
`ifdef HUNTER_FIRE_FLASH_EN
    draw_col = fire_q ? RED : DRAW_COLOUR;
`else
    draw_col = DRAW_COLOUR;
`endif
  end

  always_comb begin
    plot   = 1'b0;
    x_out  = 8'd0;
    y_out  = 7'd0;
    colour = BLACK;
    if ((state_q == ST_ERASE || state_q == ST_DRAW) && in_range) begin
      plot   = 1'b1;
      x_out  = px[7:0];
      y_out  = py[6:0];
      colour = (state_q == ST_DRAW) ? draw_col : BLACK;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign cur_x = x_q;
  assign cur_y = y_q;
`ifdef HUNTER_FIRE_FLASH_EN
  assign shot  = (state_q == ST_DONE) && fire_q;
`endif

endmodule

// File: tb/tb_hunter_crosshair.sv
// Randomised bench for hunter_crosshair against a per-pass pixel-list model of the crosshair.
// Covers reset, movement, screen-edge clipping, ignored starts, mid-pass reset and the fire flash option.
module tb_hunter_crosshair;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b0;
  logic       start    = 1'b0;
  logic       mv_left  = 1'b0;
  logic       mv_right = 1'b0;
  logic       mv_up    = 1'b0;
  logic       mv_down  = 1'b0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;
  logic [7:0] cur_x;
  logic [6:0] cur_y;
`ifdef HUNTER_FIRE_FLASH_EN
  logic       fire = 1'b0;
  logic       shot;
  localparam bit FIRE_EN = 1'b1;
`else
  localparam bit FIRE_EN = 1'b0;
`endif

  hunter_crosshair dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .start    (start),
    .mv_left  (mv_left),
    .mv_right (mv_right),
    .mv_up    (mv_up),
    .mv_down  (mv_down),
`ifdef HUNTER_FIRE_FLASH_EN
    .fire     (fire),
    .shot     (shot),
`endif
    .x_out    (x_out),
    .y_out    (y_out),
    .colour   (colour),
    .plot     (plot),
    .busy     (busy),
    .done     (done),
    .cur_x    (cur_x),
    .cur_y    (cur_y)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_pass   = 0;
  int pass_no  = 0;
  int draw_plots;

  // Reference model: crosshair centre and the shape as plain offset tables.
  int mx = 80;
  int my = 60;
  int DX[9] = '{0, -1, -2, 1, 2, 0, 0, 0, 0};
  int DY[9] = '{0, 0, 0, 0, 0, -1, -2, 1, 2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  function automatic logic [20:0] exp_pix(input int cx, input int cy, input int k,
                                          input logic [2:0] col, input bit busy_v, input bit done_v);
    int px = cx + DX[k];
    int py = cy + DY[k];
    if (px >= 0 && px <= 159 && py >= 0 && py <= 119)
      return {1'b1, 8'(px), 7'(py), col, busy_v, done_v};
    return {1'b0, 8'd0, 7'd0, 3'd0, busy_v, done_v};
  endfunction

  function automatic int sat(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // One full pass from the start cycle (c=0) to done (c=20). rnd: randomise move levels
  // every cycle; extra: cycle of a stray start pulse; abort: cycle at which reset hits.
  task automatic run_pass(input bit rnd, input bit l, input bit r, input bit u, input bit d,
                          input int extra, input bit fv, input int abort);
    int ox, oy;
    logic [2:0] col;
    logic [20:0] e;
    logic [14:0] ecur;
    bit ml, mr, mu, md;
    pass_no++;
    ox = mx; oy = my;
    col = (FIRE_EN && fv) ? 3'b100 : 3'b001;
    draw_plots = 0;
    for (int c = 0; c <= 20; c++) begin
      @(posedge CLOCK_50); #1;
      start = (c == 0) || (c == extra);
      if (rnd) {ml, mr, mu, md} = 4'($urandom);
      else {ml, mr, mu, md} = {l, r, u, d};
      mv_left = ml; mv_right = mr; mv_up = mu; mv_down = md;
`ifdef HUNTER_FIRE_FLASH_EN
      fire = (c == 0) ? fv : 1'($urandom_range(0, 1));
`endif
      if (c == abort) begin
        start = 1'b0;
        reset = 1'b0;
        #2;
        check($sformatf("p%0d rst outs", pass_no), {29'd0, plot, busy, done}, 32'd0);
        check($sformatf("p%0d rst cur", pass_no), {17'd0, cur_x, cur_y}, {17'd0, 8'd80, 7'd60});
        mx = 80; my = 60;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b1;
        return;
      end
      if (c == 10) begin
        if (ml && !mr) mx = sat(mx - 1, 159);
        if (mr && !ml) mx = sat(mx + 1, 159);
        if (mu && !md) my = sat(my - 1, 119);
        if (md && !mu) my = sat(my + 1, 119);
      end
      @(negedge CLOCK_50);
      if (c == 0)       e = 21'd0;
      else if (c <= 9)  e = exp_pix(ox, oy, c - 1, 3'b000, 1'b1, 1'b0);
      else if (c == 10) e = 21'b10;
      else if (c <= 19) e = exp_pix(mx, my, c - 11, col, 1'b1, 1'b0);
      else              e = 21'b11;
      check($sformatf("p%0d c%0d pix", pass_no, c),
            {11'd0, plot, x_out, y_out, colour, busy, done}, {11'd0, e});
      ecur = (c <= 10) ? {8'(ox), 7'(oy)} : {8'(mx), 7'(my)};
      check($sformatf("p%0d c%0d cur", pass_no, c), {17'd0, cur_x, cur_y}, {17'd0, ecur});
`ifdef HUNTER_FIRE_FLASH_EN
      check($sformatf("p%0d c%0d shot", pass_no, c), {31'd0, shot}, {31'd0, (c == 20) && fv});
`endif
      if (c >= 11 && c <= 19 && plot) draw_plots++;
    end
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int g = 0; g < n; g++) begin
      @(posedge CLOCK_50); #1;
      start = 1'b0;
      {mv_left, mv_right, mv_up, mv_down} = 4'($urandom);
      @(negedge CLOCK_50);
      check("idle outs", {10'd0, plot, x_out, y_out, colour, busy, done}, 32'd0);
    end
  endtask

  initial begin
    repeat (3) @(negedge CLOCK_50);
    check("reset outs", {10'd0, plot, x_out, y_out, colour, busy, done}, 32'd0);
    check("reset cur", {17'd0, cur_x, cur_y}, {17'd0, 8'd80, 7'd60});
    reset = 1'b1;

    run_pass(0, 0, 0, 0, 0, -1, 0, -1);

    for (int i = 0; i < 3; i++) begin
      run_pass(0, 0, 1, 0, 0, -1, 0, -1);
      check($sformatf("right cur_x %0d", i), {24'd0, cur_x}, 32'(81 + i));
    end
    check("right centre x", {24'd0, x_out}, 32'd0);

    run_pass(0, 1, 1, 0, 0, 5, 0, -1);
    check("both lr cur_x", {24'd0, cur_x}, 32'd83);
    idle_cycles(2);

    for (int i = 0; i < 84; i++) run_pass(0, 1, 0, 1, 0, -1, 0, -1);
    check("corner cur", {17'd0, cur_x, cur_y}, 32'd0);
    run_pass(0, 1, 0, 1, 0, -1, 0, -1);
    check("corner plots", 32'(draw_plots), 32'd5);

    run_pass(0, 0, 0, 0, 0, -1, 0, 14);
    run_pass(0, 0, 0, 0, 0, -1, 0, -1);

    run_pass(0, 0, 0, 0, 0, -1, 1, -1);
    run_pass(0, 0, 0, 0, 0, -1, 0, -1);

    for (int i = 0; i < 40; i++) begin
      run_pass(1, 0, 0, 0, 0, $urandom_range(1, 20), 1'($urandom_range(0, 1)), -1);
      idle_cycles($urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hunter_crosshair.md
Name: hunter_crosshair

Overview:
- Player crosshair sprite engine for the duck-hunt game.
- Sits upstream of the VGA adapter plot mux, alongside the bird drawers.
- On each frame tick from the top-level draw FSM: erases the crosshair at its old position, moves it per button levels, redraws it, then pulses done.
- Emits one pixel per clock on the (x, y, colour, plot) stream.

Parameters:
- X_MAX, 159, rightmost valid screen column (160x120 mode)
- Y_MAX, 119, bottom valid screen row
- X_INIT, 80, crosshair centre column after reset
- Y_INIT, 60, crosshair centre row after reset
- STEP, 1, pixels moved per frame per axis
- DRAW_COLOUR, 3'b001, crosshair colour

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  asynchronous, active-low; clock CLOCK_50
- start  in  1  one-cycle pulse from top FSM; begins an erase/move/draw pass
- mv_left, mv_right, mv_up, mv_down  in  1 each  level-sensitive move requests (synchronised upstream)
- x_out  out  8  pixel column
- y_out  out  7  pixel row
- colour  out  3  pixel colour
- plot  out  1  pixel write enable
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at end of pass
- cur_x  out  8  current centre column (for hit detection)
- cur_y  out  7  current centre row

Behaviour:
- Shape: 9-pixel plus, index 0..8 with offsets (dx, dy):
  - (0,0), (-1,0), (-2,0), (+1,0), (+2,0), (0,-1), (0,-2), (0,+1), (0,+2).
- States: IDLE, ERASE, UPDATE, DRAW, DONE. Registered state, 4-bit pixel index, and registered position. Outputs are a Moore decode of these.
- IDLE:
  - start=1 -> ERASE, idx=0.
  - start is ignored in all other states; no queuing.
- ERASE: 9 cycles, idx 0..8, colour=3'b000 at old position. idx==8 -> UPDATE.
- UPDATE: 1 cycle, plot=0. Position update, each axis independent:
  - left only: x -= STEP, saturating at 0.
  - right only: x += STEP, saturating at X_MAX.
  - both or neither: no x change.
  - y likewise, with up = decrement, saturating at 0 and Y_MAX.
- DRAW: 9 cycles, idx 0..8, colour=DRAW_COLOUR at new position. idx==8 -> DONE.
- DONE: 1 cycle, done=1 -> IDLE.
- Latency: start sampled in cycle 0 gives ERASE in cycles 1-9, UPDATE in 10, DRAW in 11-19, done in 20. The next start is accepted from cycle 21.
- Clipping:
  - Pixel coordinate computed as 9-bit signed centre+offset.
  - If <0 or >X_MAX (resp. Y_MAX): plot=0, x_out/y_out=0, colour=0. The pass still takes 9 cycles.
  - No wrap-around.
- Outside ERASE/DRAW: plot=0, x_out=0, y_out=0, colour=0.
- busy=1 in ERASE, UPDATE, DRAW and DONE.
- cur_x/cur_y change only in UPDATE.
- Reset (async, any time, including mid-pass):
  - state=IDLE, idx=0, position=(X_INIT, Y_INIT).
  - All stream outputs, done and busy go to 0.
  - A partially drawn crosshair is left on screen; no recovery is required.
- Move inputs are sampled only in UPDATE. Levels during other cycles have no effect.

Optional Feature:
- Macro HUNTER_FIRE_FLASH_EN.
- Defined:
  - Adds input fire (1 bit), latched on the accepted start.
  - If latched high, DRAW uses colour 3'b100 instead of DRAW_COLOUR.
  - Adds output shot (1 bit), pulsed together with done for that pass.
  - The latch clears on reset and when done is issued.
- Undefined: fire and shot ports are absent; DRAW always uses DRAW_COLOUR.

Decomposition:
- duck_hunt_pkg holds:
  - SCREEN_W=160 and SCREEN_H=120.
  - Colour constants BLACK=3'b000, BLUE=3'b001, RED=3'b100.
  - The hunter state enum.
  - CROSSHAIR_PIXELS=9.
- One sub-module: crosshair_offset_lut, a combinational map from idx[3:0] to signed dx[2:0], dy[2:0].

Test Plan:
- Reset, one start, no moves -> ERASE pixels at (80,60),(79,60),(78,60),(81,60),(82,60),(80,59),(80,58),(80,61),(80,62) in colour 0. Then the same 9 coordinates with colour 1 in cycles 11-19. done high only in cycle 20.
- mv_right held for 3 starts -> cur_x 81, 82, 83. Third DRAW centre pixel at (83,60).
- Centre at (0,0), mv_left+mv_up held, start -> cur stays (0,0). Pixels with negative offsets have plot=0, exactly 5 plots in DRAW, pass length still 20 cycles.
- mv_left and mv_right both high -> cur_x unchanged. start pulsed during busy at cycle 5 -> ignored, a single done.
- Reset asserted at cycle 14 of a pass -> plot, busy and done drop at once; cur=(80,60). A new start after release gives a full 20-cycle pass.
- HUNTER_FIRE_FLASH_EN, fire=1 at start -> DRAW colour 3'b100, shot=1 in the same cycle as done. Next pass with fire=0 -> colour 3'b001, shot stays 0.
